// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: resolves branches/jumps from the ALU flags, drives the
// fetch redirect, registers the EX payload into M and keeps branch statistics.
module ex_mem_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5,
  parameter int CNTW = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ValidE,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic [3:0]      FlagsE,
  input  logic [XLEN-1:0] WriteDataE,
  input  logic [REGW-1:0] RdE,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic [1:0]      ResultSrcE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic            StallM,
  input  logic            FlushM,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetOut,
  output logic            FlushDE,
  output logic            ValidM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [REGW-1:0] RdM,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [CNTW-1:0] BranchCount,
  output logic [CNTW-1:0] TakenCount
);

  logic flag_z, flag_c, flag_v, flag_n;
  logic cond;
  logic res;

  assign {flag_z, flag_c, flag_v, flag_n} = FlagsE;

  always_comb begin
    cond = 1'b0;
    unique case (Funct3E)
      3'b000:  cond = flag_z;
      3'b001:  cond = ~flag_z;
      3'b100:  cond = flag_n ^ flag_v;
      3'b101:  cond = ~(flag_n ^ flag_v);
      3'b110:  cond = flag_c;
      3'b111:  cond = ~flag_c;
      default: cond = 1'b0;
    endcase
  end

  // A stalled M stage means this EX instruction will be re-presented, so it
  // must not redirect or be counted until it actually advances.
  assign res         = ValidE & ~StallM;
  assign PCSrcE      = res & (JumpE | (BranchE & cond));
  assign FlushDE     = PCSrcE;
  assign PCTargetOut = PCTargetE;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ValidM      <= 1'b0;
      ALUResultM  <= '0;
      WriteDataM  <= '0;
      RdM         <= '0;
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= '0;
      PCPlus4M    <= '0;
      BranchCount <= '0;
      TakenCount  <= '0;
    end else begin
      if (res && BranchE) BranchCount <= BranchCount + 1'b1;
      if (PCSrcE)         TakenCount  <= TakenCount + 1'b1;

      if (FlushM) begin
        ValidM    <= 1'b0;
        RegWriteM <= 1'b0;
        MemWriteM <= 1'b0;
      end else if (!StallM) begin
        ValidM     <= ValidE;
        ALUResultM <= ALUResultE;
        WriteDataM <= WriteDataE;
        RdM        <= RdE;
        RegWriteM  <= ValidE & RegWriteE;
        MemWriteM  <= ValidE & MemWriteE;
        ResultSrcM <= ResultSrcE;
        PCPlus4M   <= PCPlus4E;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: a default-width instance plus a CNTW=4
// instance share one stimulus stream so counter wrap is visible quickly.
module tb_ex_mem_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ValidE;
  logic [31:0] ALUResultE;
  logic [3:0]  FlagsE;
  logic [31:0] WriteDataE;
  logic [4:0]  RdE;
  logic        RegWriteE, MemWriteE;
  logic [1:0]  ResultSrcE;
  logic        BranchE, JumpE;
  logic [2:0]  Funct3E;
  logic [31:0] PCTargetE, PCPlus4E;
  logic        StallM, FlushM;

  logic        PCSrcE, FlushDE, ValidM, RegWriteM, MemWriteM;
  logic [31:0] PCTargetOut, ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic [1:0]  ResultSrcM;
  logic [31:0] BranchCount, TakenCount;

  logic        n_PCSrcE, n_FlushDE, n_ValidM, n_RegWriteM, n_MemWriteM;
  logic [31:0] n_PCTargetOut, n_ALUResultM, n_WriteDataM, n_PCPlus4M;
  logic [4:0]  n_RdM;
  logic [1:0]  n_ResultSrcM;
  logic [3:0]  n_BranchCount, n_TakenCount;

  always #5 CLK = ~CLK;

  ex_mem_stage dut (
    .CLK(CLK), .RST(RST), .ValidE(ValidE), .ALUResultE(ALUResultE), .FlagsE(FlagsE),
    .WriteDataE(WriteDataE), .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .JumpE(JumpE), .Funct3E(Funct3E),
    .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E), .StallM(StallM), .FlushM(FlushM),
    .PCSrcE(PCSrcE), .PCTargetOut(PCTargetOut), .FlushDE(FlushDE), .ValidM(ValidM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .PCPlus4M(PCPlus4M),
    .BranchCount(BranchCount), .TakenCount(TakenCount)
  );

  ex_mem_stage #(.CNTW(4)) dut_n (
    .CLK(CLK), .RST(RST), .ValidE(ValidE), .ALUResultE(ALUResultE), .FlagsE(FlagsE),
    .WriteDataE(WriteDataE), .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .JumpE(JumpE), .Funct3E(Funct3E),
    .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E), .StallM(StallM), .FlushM(FlushM),
    .PCSrcE(n_PCSrcE), .PCTargetOut(n_PCTargetOut), .FlushDE(n_FlushDE), .ValidM(n_ValidM),
    .ALUResultM(n_ALUResultM), .WriteDataM(n_WriteDataM), .RdM(n_RdM),
    .RegWriteM(n_RegWriteM), .MemWriteM(n_MemWriteM), .ResultSrcM(n_ResultSrcM),
    .PCPlus4M(n_PCPlus4M), .BranchCount(n_BranchCount), .TakenCount(n_TakenCount)
  );

  typedef struct {
    logic        v, rw, mw;
    logic [31:0] alu, wd, pc4;
    logic [4:0]  rd;
    logic [1:0]  rs;
    bit          known;
    logic [31:0] bc, tc;
  } exp_t;

  exp_t        model;
  exp_t        sbq[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic cond_of(input logic [2:0] f3, input logic [3:0] fl);
    logic z, c, v, n;
    z = fl[3]; c = fl[2]; v = fl[1]; n = fl[0];
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n != v;
      3'b101:  return n == v;
      3'b110:  return c;
      3'b111:  return !c;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle_inputs();
    RST = 0; ValidE = 0; ALUResultE = '0; FlagsE = '0; WriteDataE = '0; RdE = '0;
    RegWriteE = 0; MemWriteE = 0; ResultSrcE = '0; BranchE = 0; JumpE = 0;
    Funct3E = '0; PCTargetE = '0; PCPlus4E = '0; StallM = 0; FlushM = 0;
  endtask

  task automatic rand_payload();
    ALUResultE = $urandom; WriteDataE = $urandom; RdE = 5'($urandom);
    ResultSrcE = 2'($urandom); PCTargetE = $urandom; PCPlus4E = $urandom;
    FlagsE = 4'($urandom); Funct3E = 3'($urandom);
    RegWriteE = 1'($urandom); MemWriteE = 1'($urandom);
  endtask

  // One cycle: check the combinational resolve, predict M, clock, compare M.
  task automatic step();
    logic res, take;
    exp_t e;
    #1;
    res  = ValidE && !StallM;
    take = res && (JumpE || (BranchE && cond_of(Funct3E, FlagsE)));
    chk("pcsrc", PCSrcE, take);
    chk("flushde", FlushDE, take);
    chk("pctarget", PCTargetOut, PCTargetE);
    chk("pcsrc_n", n_PCSrcE, take);
    if (RST) begin
      model = '{v: 0, rw: 0, mw: 0, alu: 0, wd: 0, pc4: 0, rd: 0, rs: 0, known: 1, bc: 0, tc: 0};
    end else begin
      if (res && BranchE) model.bc++;
      if (take)           model.tc++;
      if (FlushM) begin
        model.v = 0; model.rw = 0; model.mw = 0; model.known = 0;
      end else if (!StallM) begin
        model.v = ValidE; model.rw = ValidE && RegWriteE; model.mw = ValidE && MemWriteE;
        model.alu = ALUResultE; model.wd = WriteDataE; model.pc4 = PCPlus4E;
        model.rd = RdE; model.rs = ResultSrcE; model.known = 1;
      end
    end
    sbq.push_back(model);
    @(posedge CLK);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sbq.pop_front();
      chk("validm", ValidM, e.v);
      chk("regwritem", RegWriteM, e.rw);
      chk("memwritem", MemWriteM, e.mw);
      chk("bcount", BranchCount, e.bc);
      chk("tcount", TakenCount, e.tc);
      chk("bcount_n", n_BranchCount, e.bc[3:0]);
      chk("tcount_n", n_TakenCount, e.tc[3:0]);
      if (e.known) begin
        chk("alum", ALUResultM, e.alu);
        chk("wdm", WriteDataM, e.wd);
        chk("pc4m", PCPlus4M, e.pc4);
        chk("rdm", RdM, e.rd);
        chk("rsm", ResultSrcM, e.rs);
        chk("alum_n", n_ALUResultM, e.alu);
      end
    end
  endtask

  task automatic branch(input logic [2:0] f3, input logic [3:0] fl, input logic want);
    idle_inputs();
    ValidE = 1; BranchE = 1; Funct3E = f3; FlagsE = fl; PCTargetE = 32'h200;
    #1;
    chk("cond_tbl", PCSrcE, want);
    step();
  endtask

  initial begin
    idle_inputs();
    model = '{v: 0, rw: 0, mw: 0, alu: 0, wd: 0, pc4: 0, rd: 0, rs: 0, known: 0, bc: 0, tc: 0};
    @(posedge CLK); #1;

    // reset with random E inputs
    for (int i = 0; i < 2; i++) begin
      rand_payload(); ValidE = 1; BranchE = 1; RST = 1;
      #1;
      chk("pcsrc_qual", PCSrcE & ~RST, 0);
      step();
    end
    chk("rst_alum", ALUResultM, 0);

    // BEQ taken
    idle_inputs();
    ValidE = 1; BranchE = 1; Funct3E = 3'b000; FlagsE = 4'b1000; PCTargetE = 32'h100;
    #1;
    chk("beq_pcsrc", PCSrcE, 1);
    chk("beq_tgt", PCTargetOut, 32'h100);
    step();
    chk("beq_bc", BranchCount, 1);
    chk("beq_tc", TakenCount, 1);

    // signed vs unsigned compares
    branch(3'b100, 4'b0001, 1);
    branch(3'b110, 4'b0001, 0);
    branch(3'b110, 4'b0100, 1);
    branch(3'b111, 4'b0100, 0);
    branch(3'b010, 4'b1111, 0);
    branch(3'b001, 4'b0000, 1);
    branch(3'b101, 4'b0011, 1);

    // stall holds M and blocks resolution
    idle_inputs();
    ValidE = 1; RegWriteE = 1; ALUResultE = 32'hDEADBEEF;
    step();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      ValidE = 1; ALUResultE = 32'h12345678; BranchE = 1; FlagsE = 4'b1000; StallM = 1;
      step();
    end
    chk("stall_alum", ALUResultM, 32'hDEADBEEF);

    // flush beats stall
    idle_inputs();
    ValidE = 1; RegWriteE = 1; MemWriteE = 1; StallM = 1; FlushM = 1;
    step();
    chk("flush_validm", ValidM, 0);

    // flush does not block counting
    idle_inputs();
    ValidE = 1; BranchE = 1; FlagsE = 4'b1000; FlushM = 1;
    step();

    // bubble load squashes write enables
    idle_inputs();
    rand_payload(); ValidE = 0; RegWriteE = 1; MemWriteE = 1;
    step();

    // illegal branch+jump behaves as a jump counted in both
    idle_inputs();
    ValidE = 1; BranchE = 1; JumpE = 1; Funct3E = 3'b010;
    step();

    // counter wrap on the narrow instance
    idle_inputs(); RST = 1; step();
    for (int i = 0; i < 16; i++) begin
      idle_inputs(); ValidE = 1; JumpE = 1; PCTargetE = 32'(i * 4);
      step();
    end
    chk("wrap_tc_n", n_TakenCount, 0);
    chk("wrap_bc_n", n_BranchCount, 0);
    chk("wrap_tc", TakenCount, 16);

    // invalid jump does nothing
    idle_inputs(); ValidE = 0; JumpE = 1;
    #1;
    chk("bubble_jump", PCSrcE, 0);
    step();

    // random traffic with occasional mid-operation reset
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      rand_payload();
      ValidE  = ($urandom_range(0, 9) < 8);
      JumpE   = ($urandom_range(0, 9) < 2);
      BranchE = !JumpE && ($urandom_range(0, 9) < 5);
      StallM  = ($urandom_range(0, 9) < 2);
      FlushM  = ($urandom_range(0, 9) < 1);
      RST     = ($urandom_range(0, 99) < 3);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Consumes the execute-stage ALU result and its Z/C/V/N flags.
- Resolves conditional branches and jumps, and drives the PC-select and flush signals back to fetch/decode/execute.
- Registers the EX→MEM pipeline payload, with stall and flush support.
- Keeps two 32-bit branch performance counters.

Parameters:
- XLEN, 32, datapath width of result, store data, PC.
- REGW, 5, register index width.
- CNTW, 32, performance counter width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ValidE  in  1  EX holds a real instruction (0 = bubble).
- ALUResultE  in  XLEN  ALU result.
- FlagsE  in  4  {Z,C,V,N} from the ALU. C is bit XLEN of the (XLEN+1)-bit A+B or A-B; for SUB, C=1 means borrow (A<B unsigned).
- WriteDataE  in  XLEN  store data.
- RdE  in  REGW  destination register.
- RegWriteE  in  1  register write enable.
- MemWriteE  in  1  memory write enable.
- ResultSrcE  in  2  writeback select.
- BranchE  in  1  conditional branch.
- JumpE  in  1  JAL/JALR.
- Funct3E  in  3  branch condition.
- PCTargetE  in  XLEN  branch/jump target.
- PCPlus4E  in  XLEN  link address.
- StallM  in  1  hold the M register.
- FlushM  in  1  insert a bubble into M.
- PCSrcE  out  1  redirect fetch to PCTargetE.
- PCTargetOut  out  XLEN  equals PCTargetE.
- FlushDE  out  1  kill the D and E stages.
- ValidM, ALUResultM, WriteDataM, RdM, RegWriteM, MemWriteM, ResultSrcM, PCPlus4M  out  (widths as the E inputs)  registered payload.
- BranchCount  out  CNTW  resolved conditional branches.
- TakenCount  out  CNTW  taken conditional branches plus jumps.

Behaviour:
- Condition decode (combinational, from FlagsE):
  - 000 BEQ: Z
  - 001 BNE: ~Z
  - 100 BLT: N^V
  - 101 BGE: ~(N^V)
  - 110 BLTU: C
  - 111 BGEU: ~C
  - 010, 011: never taken.
- Resolution gate: res = ValidE & ~StallM.
- PCSrcE = res & (JumpE | (BranchE & cond)). Combinational, zero latency.
- FlushDE = PCSrcE. PCTargetOut = PCTargetE.
- M register update priority: RST > FlushM > StallM > load.
  - RST: all M outputs = 0.
  - FlushM: ValidM, RegWriteM, MemWriteM = 0. Payload fields hold their previous value (don't-care).
  - StallM: all M outputs hold.
  - Load: every M output = its E input, with ValidM = ValidE.
- Bubble input: a load with ValidE=0 forces RegWriteM=MemWriteM=0 regardless of RegWriteE/MemWriteE.
- Latency: one cycle E→M.
- Counters:
  - BranchCount += 1 when res & BranchE.
  - TakenCount += 1 when PCSrcE.
  - Both wrap modulo 2^CNTW and both reset to 0.
  - FlushM does not block counting; a branch resolved in E with FlushM asserted still counts.
- Reset mid-operation: a RST cycle forces PCSrcE/FlushDE to be ignored downstream. The block itself still computes them combinationally; fetch gates them with RST. Counters and the M register clear on that edge.
- Simultaneous StallM & FlushM: the flush wins and the M register bubbles.
- BranchE & JumpE both set is illegal. The block treats it as a jump: counted once in TakenCount, and counted in BranchCount.

Test Plan:
- Reset: RST=1 for 2 cycles with random E inputs → all M outputs 0, PCSrcE qualified off, both counts 0.
- BEQ taken: ValidE=1, BranchE=1, Funct3=000, FlagsE=1000, PCTargetE=0x100 → PCSrcE=1, FlushDE=1, PCTargetOut=0x100; next edge BranchCount=1, TakenCount=1.
- Signed vs unsigned:
  - FlagsE=0001 (N=1, V=0): Funct3=100 → taken; Funct3=110 → not taken.
  - FlagsE=0100 (C=1): Funct3=110 → taken; Funct3=111 → not taken.
- Stall: load ALUResultE=0xDEADBEEF, then StallM=1 for 3 cycles with ALUResultE=0x12345678 and a taken BEQ → ALUResultM stays 0xDEADBEEF, PCSrcE=0, counters unchanged.
- Flush vs stall: StallM=1 and FlushM=1 with RegWriteE=1 → next cycle ValidM=0, RegWriteM=0, MemWriteM=0.
- Counter wrap: with CNTW=4, 16 taken JAL (JumpE=1) → TakenCount returns to 0, BranchCount stays 0; ValidE=0 jump → no count, PCSrcE=0.
